// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi survivor-memory sequencing logic.
package viterbi_pkg;
  localparam int ADDR_W_DEFAULT = 10;
  localparam int NUM_BANKS      = 4;

  typedef logic [1:0] bank_idx_t;

  typedef enum logic [1:0] {IDLE, FILL0, FILL1, RUN} ctrl_state_e;
endpackage

// File: rtl/trellis_bank_map.sv
// Role map: write bank b at wr_cnt, read banks b+1/b+3 at rd_cnt, park bank b+2 at 0.
module trellis_bank_map
  import viterbi_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  bank_idx_t                             b,
  input  logic [ADDR_W-1:0]                     wr_cnt,
  input  logic [ADDR_W-1:0]                     rd_cnt,
  output logic [NUM_BANKS-1:0][ADDR_W-1:0]      addr,
  output logic [NUM_BANKS-1:0]                  wr
);
  always_comb begin
    addr = '0;
    wr   = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      case (bank_idx_t'(i) - b)
        2'd0:    begin addr[i] = wr_cnt; wr[i] = 1'b1; end
        2'd2:    addr[i] = '0;
        default: addr[i] = rd_cnt;
      endcase
    end
  end
endmodule

// File: rtl/trellis_mem_ctrl.sv
// Survivor-memory sequencer: address counters, bank rotation, TBU start and display ping-pong.
// Optional TRELLIS_STALL_EN adds a stall input that freezes counters, bank and FSM.
module trellis_mem_ctrl
  import viterbi_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEFAULT,
  parameter int DISP_WR_INIT = 2,
  parameter int DISP_RD_INIT = 2**ADDR_W - 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
`ifdef TRELLIS_STALL_EN
  input  logic                              stall,
`endif
  output logic [NUM_BANKS-1:0][ADDR_W-1:0]  bank_addr,
  output logic [NUM_BANKS-1:0]              bank_wr,
  output logic [1:0]                        tbu_en,
  output bank_idx_t                         tbu0_src0,
  output bank_idx_t                         tbu0_src1,
  output bank_idx_t                         tbu1_src0,
  output bank_idx_t                         tbu1_src1,
  output logic [1:0]                        tbu_sel,
  output logic [1:0][ADDR_W-1:0]            disp_addr,
  output logic                              out_sel,
  output logic                              run
);
  logic                             hold, advance, wrap;
  logic [ADDR_W-1:0]                wr_cnt, rd_cnt, dwr, drd;
  bank_idx_t                        bank, p;
  bank_idx_t                        bank_pipe [2];
  logic [3:0]                       b0_pipe;
  logic                             q;
  ctrl_state_e                      state;
  logic [NUM_BANKS-1:0][ADDR_W-1:0] map_addr;
  logic [NUM_BANKS-1:0]             map_wr;

`ifdef TRELLIS_STALL_EN
  assign hold = enable & stall;
`else
  assign hold = 1'b0;
`endif
  assign advance = enable & ~hold;
  assign wrap    = &wr_cnt;
  assign rd_cnt  = ~wr_cnt;
  assign p       = bank_pipe[1];
  assign q       = b0_pipe[2];

  trellis_bank_map #(.ADDR_W(ADDR_W)) u_map (
    .b      (bank),
    .wr_cnt (wr_cnt),
    .rd_cnt (rd_cnt),
    .addr   (map_addr),
    .wr     (map_wr)
  );

  // bank survives enable drops; only rst clears it
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_cnt <= '0;
      bank   <= '0;
      dwr    <= ADDR_W'(DISP_WR_INIT);
      drd    <= ADDR_W'(DISP_RD_INIT);
    end else if (!enable) begin
      wr_cnt <= '0;
      dwr    <= ADDR_W'(DISP_WR_INIT);
      drd    <= ADDR_W'(DISP_RD_INIT);
    end else if (!hold) begin
      wr_cnt <= wr_cnt + 1'b1;
      dwr    <= dwr - 1'b1;
      drd    <= drd + 1'b1;
      if (wrap) bank <= bank + 1'b1;
    end
  end

  // delay pipes keep shifting through stalls
  always_ff @(posedge clk) begin
    if (!rst) begin
      bank_pipe[0] <= '0;
      bank_pipe[1] <= '0;
      b0_pipe      <= '0;
    end else begin
      bank_pipe[0] <= bank;
      bank_pipe[1] <= bank_pipe[0];
      b0_pipe      <= {b0_pipe[2:0], bank[0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bank_addr <= '0;
      bank_wr   <= '0;
      tbu_en    <= '0;
      tbu0_src0 <= '0;
      tbu0_src1 <= '0;
      tbu1_src0 <= '0;
      tbu1_src1 <= '0;
      tbu_sel   <= '0;
      disp_addr <= '0;
      out_sel   <= 1'b0;
    end else begin
      bank_addr <= map_addr;
      bank_wr   <= advance ? map_wr : '0;
      tbu_en    <= tbu_en | {p == 2'd3, p == 2'd2};
      tbu0_src0 <= p[1] ? 2'd1 : 2'd3;
      tbu0_src1 <= p[1] ? 2'd0 : 2'd2;
      tbu1_src0 <= (p == 2'd0 || p == 2'd3) ? 2'd2 : 2'd0;
      tbu1_src1 <= (p == 2'd0 || p == 2'd3) ? 2'd1 : 2'd3;
      tbu_sel   <= {~p[0], p[0]};
      disp_addr[0] <= q ? dwr : drd;
      disp_addr[1] <= q ? drd : dwr;
      out_sel   <= b0_pipe[3];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      run   <= 1'b0;
    end else if (!enable) begin
      state <= IDLE;
      run   <= 1'b0;
    end else if (!hold) begin
      case (state)
        IDLE:    state <= FILL0;
        FILL0:   if (wrap) state <= FILL1;
        FILL1:   if (wrap) begin state <= RUN; run <= 1'b1; end
        default: begin state <= RUN; run <= 1'b1; end
      endcase
    end
  end
endmodule

// File: tb/tb_trellis_mem_ctrl.sv
// Scoreboard bench for trellis_mem_ctrl: a behavioural model queues expected outputs per edge.
module tb_trellis_mem_ctrl;
  localparam int AW = 10;
  localparam int N  = 1 << AW;

  typedef struct packed {
    logic [3:0][AW-1:0] ba;
    logic [3:0]         bw;
    logic [1:0]         te;
    logic [1:0]         s00, s01, s10, s11;
    logic [1:0]         sel;
    logic [1:0][AW-1:0] da;
    logic               os;
    logic               run;
  } obs_t;

  logic clk = 1'b0;
  logic rst, enable, stall;
  logic [3:0][AW-1:0] bank_addr;
  logic [3:0]         bank_wr;
  logic [1:0]         tbu_en, tbu0_src0, tbu0_src1, tbu1_src0, tbu1_src1, tbu_sel;
  logic [1:0][AW-1:0] disp_addr;
  logic               out_sel, run;

  int vectors = 0, miscompares = 0;
  obs_t exp_q[$];

  // behavioural model state
  int m_wr, m_bank, m_dwr, m_drd, m_phase;  // m_phase: 0 idle, 1 first fill, 2 second fill, 3 running
  int hist[4];                              // bank value sampled 1..4 edges ago
  bit m_te0, m_te1;

  always #5 clk = ~clk;

  trellis_mem_ctrl dut (
    .clk(clk), .rst(rst), .enable(enable),
`ifdef TRELLIS_STALL_EN
    .stall(stall),
`endif
    .bank_addr(bank_addr), .bank_wr(bank_wr), .tbu_en(tbu_en),
    .tbu0_src0(tbu0_src0), .tbu0_src1(tbu0_src1),
    .tbu1_src0(tbu1_src0), .tbu1_src1(tbu1_src1),
    .tbu_sel(tbu_sel), .disp_addr(disp_addr), .out_sel(out_sel), .run(run)
  );

  always @(posedge clk) begin
    obs_t e;
    bit hold;
    int p, q;
    e = '0;
    if (!rst) begin
      m_wr = 0; m_bank = 0; m_dwr = 2; m_drd = N - 3; m_phase = 0;
      m_te0 = 0; m_te1 = 0;
      for (int i = 0; i < 4; i++) hist[i] = 0;
    end else begin
`ifdef TRELLIS_STALL_EN
      hold = enable && stall;
`else
      hold = 0;
`endif
      for (int k = 0; k < 4; k++) begin
        int r;
        r = (k - m_bank + 4) % 4;
        e.ba[k] = (r == 0) ? AW'(m_wr) : (r == 2) ? '0 : AW'(N - 1 - m_wr);
      end
      e.bw = (enable && !hold) ? 4'(1 << m_bank) : 4'b0;
      p = hist[1];
      if (p == 2) m_te0 = 1;
      if (p == 3) m_te1 = 1;
      e.te  = {m_te1, m_te0};
      e.s00 = (p >= 2) ? 2'd1 : 2'd3;
      e.s01 = (p >= 2) ? 2'd0 : 2'd2;
      e.s10 = (p == 0 || p == 3) ? 2'd2 : 2'd0;
      e.s11 = (p == 0 || p == 3) ? 2'd1 : 2'd3;
      e.sel = (p % 2 == 1) ? 2'b01 : 2'b10;
      q = hist[2] % 2;
      e.da[0] = AW'(q ? m_dwr : m_drd);
      e.da[1] = AW'(q ? m_drd : m_dwr);
      e.os = 1'(hist[3] % 2);
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = m_bank;
      if (!enable) begin
        m_phase = 0; m_wr = 0; m_dwr = 2; m_drd = N - 3;
      end else if (!hold) begin
        if (m_phase == 0) m_phase = 1;
        else if (m_wr == N - 1 && m_phase < 3) m_phase++;
        if (m_wr == N - 1) m_bank = (m_bank + 1) % 4;
        m_wr  = (m_wr + 1) % N;
        m_dwr = (m_dwr + N - 1) % N;
        m_drd = (m_drd + 1) % N;
      end
      e.run = (m_phase == 3);
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bank_addr, bank_wr, tbu_en, tbu0_src0, tbu0_src1, tbu1_src0, tbu1_src1,
           tbu_sel, disp_addr, out_sel, run};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL outputs @%0t: got ba=%h bw=%b te=%b src=%h sel=%b da=%h os=%b run=%b, want ba=%h bw=%b te=%b src=%h sel=%b da=%h os=%b run=%b",
                 $time, a.ba, a.bw, a.te, {a.s00, a.s01, a.s10, a.s11}, a.sel, a.da, a.os, a.run,
                 e.ba, e.bw, e.te, {e.s00, e.s01, e.s10, e.s11}, e.sel, e.da, e.os, e.run);
      end
    end
  end

  task automatic wait_wr(input int target, input string what);
    int n;
    n = 0;
    while (m_wr != target && n < 4 * N) begin
      @(negedge clk);
      n++;
    end
    if (m_wr != target) begin
      miscompares++;
      $display("FAIL timeout %s: wr index %0d, want %0d", what, m_wr, target);
    end
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; stall = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    // three wraps of continuous enable: fill, run, both TBUs started
    enable = 1'b1;
    repeat (3 * N + 100) @(negedge clk);
    // enable drop mid-block
    wait_wr(500, "enable-drop");
    enable = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    repeat (N + 50) @(negedge clk);
`ifdef TRELLIS_STALL_EN
    wait_wr(N - 1, "stall-at-wrap");
    stall = 1'b1;
    repeat (5) @(negedge clk);
    stall = 1'b0;
    repeat (20) @(negedge clk);
`endif
    // mid-operation reset
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    // randomized enable drops and stalls
    for (int i = 0; i < 6000; i++) begin
      enable = ($urandom_range(0, 199) != 0);
`ifdef TRELLIS_STALL_EN
      stall = ($urandom_range(0, 9) == 0);
`endif
      @(negedge clk);
    end
    enable = 1'b1;
    stall = 1'b0;
    repeat (2 * N + 10) @(negedge clk);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
